// File: rtl/prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : prog_encoder
// Description : Instruction encoder and instruction-memory loader. Accepts
//               symbolic instructions (mnemonic + fields) over a valid/ready
//               handshake, encodes each one into a 32-bit MIPS word and writes
//               the words sequentially into instruction memory through an
//               acknowledged write port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_WIDTH : instruction-memory word-address width (2^ADDR_WIDTH words)
//   BASE_ADDR  : first word address written after start
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a new program load (honoured in IDLE/DONE/ERROR)
//   in_valid/ready  : instruction request handshake
//   in_op           : mnemonic (0 ADD .. 10 ANDI, 11-15 illegal)
//   in_rs/rt/rd     : register fields
//   in_imm          : immediate/offset, passed through unmodified
//   in_target       : jump target field
//   in_last         : final instruction of the program
//   mem_we/addr/wdata/ack : acknowledged instruction-memory write port
//   busy, done, err : status (ACCEPT|WRITE, DONE, ERROR)
//   count           : words written since last start
// ============================================================================
module prog_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [ADDR_WIDTH-1:0] c_base     = ADDR_WIDTH'(BASE_ADDR);
  // Number of words that fit in memory; reaching it without "last" overflows.
  localparam logic [ADDR_WIDTH:0]   c_capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Mnemonic codes presented on in_op
  localparam logic [3:0] c_mn_add  = 4'd0;
  localparam logic [3:0] c_mn_and  = 4'd1;
  localparam logic [3:0] c_mn_jr   = 4'd2;
  localparam logic [3:0] c_mn_lw   = 4'd3;
  localparam logic [3:0] c_mn_sw   = 4'd4;
  localparam logic [3:0] c_mn_beq  = 4'd5;
  localparam logic [3:0] c_mn_bne  = 4'd6;
  localparam logic [3:0] c_mn_j    = 4'd7;
  localparam logic [3:0] c_mn_jal  = 4'd8;
  localparam logic [3:0] c_mn_addi = 4'd9;
  localparam logic [3:0] c_mn_andi = 4'd10;

  // Primary opcodes understood by the controller
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_andi  = 6'b001100;

  // R-type function codes
  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_and   = 6'b100100;
  localparam logic [5:0] c_fn_jr    = 6'b001000;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_last;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_legal;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic                  w_accept;
  logic                  w_restart;

  // --------------------------------------------------------------------------
  // Instruction encoder (purely combinational on the request fields)
  // --------------------------------------------------------------------------
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'd0;
    case (in_op)
      c_mn_add:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_add};
      c_mn_and:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_and};
      c_mn_jr:   w_word = {c_op_rtype, in_rs, 15'd0, c_fn_jr};
      c_mn_lw:   w_word = {c_op_lw,   in_rs, in_rt, in_imm};
      c_mn_sw:   w_word = {c_op_sw,   in_rs, in_rt, in_imm};
      c_mn_beq:  w_word = {c_op_beq,  in_rs, in_rt, in_imm};
      c_mn_bne:  w_word = {c_op_bne,  in_rs, in_rt, in_imm};
      c_mn_j:    w_word = {c_op_j,    in_target};
      c_mn_jal:  w_word = {c_op_jal,  in_target};
      c_mn_addi: w_word = {c_op_addi, in_rs, in_rt, in_imm};
      c_mn_andi: w_word = {c_op_andi, in_rs, in_rt, in_imm};
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_count_inc = r_count + (ADDR_WIDTH + 1)'(1);
  // A request is consumed whenever it is offered in ACCEPT, legal or not.
  assign w_accept    = (r_state == ST_ACCEPT) && in_valid;
  // start is only honoured from the resting states.
  assign w_restart   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_next_state = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          w_next_state = w_legal ? ST_WRITE : ST_ERROR;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (r_last) begin
            w_next_state = ST_DONE;
          end else if (w_count_inc == c_capacity) begin
            // Memory is full and the program has not finished.
            w_next_state = ST_ERROR;
          end else begin
            w_next_state = ST_ACCEPT;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= c_base;
      r_wdata <= 32'd0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_restart) begin
        r_addr  <= c_base;
        r_count <= '0;
      end
      if (w_accept && w_legal) begin
        r_wdata <= w_word;
        r_last  <= in_last;
      end
      if ((r_state == ST_WRITE) && mem_ack) begin
        // Natural wrap modulo 2^ADDR_WIDTH.
        r_addr  <= r_addr + ADDR_WIDTH'(1);
        r_count <= w_count_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == ST_ACCEPT);
  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state == ST_ACCEPT) || (r_state == ST_WRITE);
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_ERROR);
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_encoder
// Description : Self-checking bench for prog_encoder. Stimulus pushes the
//               expected {address, word} of every legal instruction into a
//               scoreboard queue; an independent memory-side process acks
//               writes after random or fixed delays and compares each write
//               against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_encoder;

  localparam int AW   = 3;
  localparam int BASE = 5;
  localparam int CAP  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  prog_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries: {address, word}
  logic [AW+31:0] exp_q[$];
  int             addr_exp;
  int             cnt_exp;

  // Memory-side controls
  bit ack_enable  = 1'b1;
  bit ack_force   = 1'b0;
  int fixed_delay = -1;
  int stall       = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference encoder: opcode/func tables indexed by mnemonic, then the field
  // layout by instruction class.
  function automatic logic [31:0] model_word(input int op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    logic [5:0] opc[11];
    logic [5:0] fn;
    opc = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0C};
    if (op == 0 || op == 1) begin
      fn = (op == 0) ? 6'd32 : 6'd36;
      return {opc[op], rs, rt, rd, 5'd0, fn};
    end else if (op == 2) begin
      return {6'd0, rs, 15'd0, 6'd8};
    end else if (op == 7 || op == 8) begin
      return {opc[op], tgt};
    end
    return {opc[op], rs, rt, imm};
  endfunction

  // Memory side / monitor: decides ack each cycle and checks every cycle of
  // every write against the scoreboard head.
  always @(negedge clk) begin
    if (!ack_enable) begin
      mem_ack = ack_force;
    end else if (mem_we) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
        mem_ack = 1'b1;
      end else begin
        chk("write_addr",  64'(mem_addr),  64'(exp_q[0][AW+31:32]));
        chk("write_data",  64'(mem_wdata), 64'(exp_q[0][31:0]));
        chk("ready_in_write", 64'(in_ready), 64'd0);
        if (stall < 0) stall = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        if (stall == 0) begin
          mem_ack = 1'b1;
          void'(exp_q.pop_front());
          stall = -1;
        end else begin
          mem_ack = 1'b0;
          stall--;
        end
      end
    end else begin
      // Spurious acks outside WRITE must be ignored.
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    addr_exp = BASE;
    cnt_exp  = 0;
    chk("start_count", 64'(count), 64'd0);
    chk("start_addr",  64'(mem_addr), 64'(BASE));
    chk("start_err",   64'(err), 64'd0);
    chk("start_done",  64'(done), 64'd0);
    chk("start_ready", 64'(in_ready), 64'd1);
  endtask

  // Issue one request; dir[32] selects an externally known expected word.
  task automatic send(input int op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
      input bit last, input logic [32:0] dir);
    int  n = 0;
    bit  legal;
    logic [31:0] w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("ready_timeout");
      return;
    end
    chk("count_at_ready", 64'(count), 64'(cnt_exp));
    in_valid  = 1'b1;
    in_op     = 4'(op);
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
    start     = ($urandom_range(0, 5) == 0);  // must be ignored in ACCEPT
    @(posedge clk);
    legal = (op <= 10);
    if (legal) begin
      w = dir[32] ? dir[31:0] : model_word(op, rs, rt, rd, imm, tgt);
      exp_q.push_back({AW'(addr_exp), w});
      addr_exp = (addr_exp + 1) % CAP;
      cnt_exp++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (legal) begin
      chk("latency_we", 64'(mem_we), 64'd1);
    end else begin
      chk("illegal_err",   64'(err), 64'd1);
      chk("illegal_no_we", 64'(mem_we), 64'd0);
      chk("illegal_count", 64'(count), 64'(cnt_exp));
    end
  endtask

  task automatic wait_end(input bit exp_done);
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) fail_now("end_timeout");
    chk("end_done",  64'(done),  64'(exp_done));
    chk("end_err",   64'(err),   64'(!exp_done));
    chk("end_count", 64'(count), 64'(cnt_exp));
    chk("end_busy",  64'(busy),  64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_random(input int len, input bit allow_illegal);
    int  op;
    bit  last;
    do_start();
    for (int i = 0; i < len; i++) begin
      op   = (allow_illegal && $urandom_range(0, 9) == 0) ? int'($urandom_range(11, 15))
                                                          : int'($urandom_range(0, 10));
      last = (i == len - 1);
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
           last, 33'd0);
      if (op > 10) begin
        wait_end(1'b0);
        return;
      end
      if (cnt_exp == CAP && !last) begin
        wait_end(1'b0);  // overflow
        return;
      end
    end
    wait_end(1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    mem_ack = 1'b0;
    addr_exp = BASE;
    cnt_exp  = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we",    64'(mem_we), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'(BASE));
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_err",   64'(err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b0;

    // Directed program with hand-encoded words; addresses wrap 5,6,7,0,1.
    do_start();
    send(0, 5'd1,  5'd2, 5'd3, 16'h0,    26'h0,  1'b0, {1'b1, 32'h00221820});
    send(3, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0,  1'b0, {1'b1, 32'h8FA80004});
    send(5, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,  1'b0, {1'b1, 32'h1022FFFF});
    send(7, 5'd0,  5'd0, 5'd0, 16'h0,    26'h10, 1'b0, {1'b1, 32'h08000010});
    send(2, 5'd31, 5'd0, 5'd0, 16'h0,    26'h0,  1'b1, {1'b1, 32'h03E00008});
    wait_end(1'b1);

    // Illegal mnemonic, then recovery by start.
    do_start();
    send(12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0, 33'd0);
    wait_end(1'b0);

    // Long memory stall: write must hold for 5 cycles.
    fixed_delay = 5;
    do_start();
    send(9,  5'd4, 5'd5, 5'd0, 16'h00AB, 26'h0, 1'b0, 33'd0);
    send(10, 5'd6, 5'd7, 5'd0, 16'hF00F, 26'h0, 1'b1, 33'd0);
    wait_end(1'b1);
    fixed_delay = -1;

    // Overflow: more words than memory holds, no last before capacity.
    run_random(CAP + 2, 1'b0);

    // Reset in the middle of a write abandons it.
    ack_enable = 1'b0;
    ack_force  = 1'b0;
    do_start();
    send(1, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 1'b0, 33'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_we",    64'(mem_we), 64'd0);
    chk("midrst_busy",  64'(busy), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_addr",  64'(mem_addr), 64'(BASE));
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack_we",    64'(mem_we), 64'd0);
      chk("late_ack_busy",  64'(busy), 64'd0);
      chk("late_ack_count", 64'(count), 64'd0);
    end
    ack_force = 1'b0;
    exp_q.delete();
    stall      = -1;
    ack_enable = 1'b1;

    // Randomized programs.
    for (int p = 0; p < 20; p++) begin
      run_random(int'($urandom_range(1, CAP + 2)), 1'b1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
